// File: rtl/bmem_line_adapter_if.sv
// bmem_line_adapter_if
//   Bundles the line-request side (from the arbiter) and the beat-level bmem
//   side of bmem_line_adapter into one interface.
//   modport master : used by the adapter. It accepts line requests and masters
//                    the bmem bus.
//   modport slave  : used by the environment, meaning the arbiter plus the
//                    bmem model.
//   Request side : req_addr/req_read/req_write/req_wdata in, req_ready out,
//                  resp/resp_rdata/resp_raddr/err_mismatch out.
//   bmem side    : bmem_addr/bmem_read/bmem_write/bmem_wdata out,
//                  bmem_ready/bmem_raddr/bmem_rdata/bmem_rvalid in.
interface bmem_line_adapter_if #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
);
  logic [31:0]          req_addr;
  logic                 req_read;
  logic                 req_write;
  logic [LINE_BITS-1:0] req_wdata;
  logic                 req_ready;
  logic                 resp;
  logic [LINE_BITS-1:0] resp_rdata;
  logic [31:0]          resp_raddr;
  logic                 err_mismatch;

  logic [31:0]          bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [31:0]          bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  modport master (
    input  req_addr, req_read, req_write, req_wdata,
    output req_ready, resp, resp_rdata, resp_raddr, err_mismatch,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    output req_addr, req_read, req_write, req_wdata,
    input  req_ready, resp, resp_rdata, resp_raddr, err_mismatch,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter
//   Turns one LINE_BITS cache-line request into a BEAT_BITS burst on bmem.
//   Read bursts are reassembled into a full line. Completion is reported with
//   a single resp pulse.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  bmem_line_adapter_if.master, which carries the request/response and
//          bmem signals
//
//   Optional feature: `BMEM_RADDR_CHECK_EN.
//     When it is defined, read beats whose bmem_raddr[31:5] does not match the
//     line being read are dropped, and err_mismatch pulses for that cycle.
//     When it is not defined, every beat is taken and err_mismatch stays 0.
module bmem_line_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  bmem_line_adapter_if.master   bus
);
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR, RESP} state_e;
  typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;
  typedef struct packed {
    logic [31:0] addr;
    line_t       wdata;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q;
  logic [CNT_W-1:0] beat_cnt;
  line_t            line_q, line_next, rdata_q;
  logic             accept, last_beat, tag_ok, beat_take, wr_go;
  logic             unused_ok;

  assign accept    = (state_q == IDLE) && (bus.req_read || bus.req_write);
  assign last_beat = (beat_cnt == CNT_W'(BEATS-1));

`ifdef BMEM_RADDR_CHECK_EN
  assign tag_ok    = (bus.bmem_raddr[31:5] == req_q.addr[31:5]);
  assign unused_ok = ^{bus.req_addr[4:0], bus.bmem_raddr[4:0]};
`else
  assign tag_ok    = 1'b1;
  assign unused_ok = ^{bus.req_addr[4:0], bus.bmem_raddr};
`endif

  // Read beats count only in RD_DATA. Beats arriving in any other state are dropped.
  assign beat_take = (state_q == RD_DATA) && bus.bmem_rvalid && tag_ok;
  assign wr_go     = (state_q == WR) && bus.bmem_ready;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                 state_d = bus.req_write ? WR : RD_CMD;
      RD_CMD:  if (bus.bmem_ready)         state_d = RD_DATA;
      RD_DATA: if (beat_take && last_beat) state_d = RESP;
      WR:      if (wr_go && last_beat)     state_d = RESP;
      RESP:                                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.bmem_read    = 1'b0;
    bus.bmem_write   = 1'b0;
    bus.resp         = 1'b0;
    bus.bmem_addr    = '0;
    bus.bmem_wdata   = '0;
    bus.err_mismatch = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready = 1'b1;
      RD_CMD: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = req_q.addr;
      end
`ifdef BMEM_RADDR_CHECK_EN
      RD_DATA: bus.err_mismatch = bus.bmem_rvalid && !tag_ok;
`endif
      WR: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = req_q.addr;
        bus.bmem_wdata = req_q.wdata[beat_cnt];
      end
      RESP:    bus.resp = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_raddr = req_q.addr;

  // ---------------- datapath ----------------
  // The request is latched once at accept. Later changes on req_* are ignored
  // until the adapter returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.addr  <= {bus.req_addr[31:5], 5'b0};
      req_q.wdata <= line_t'(bus.req_wdata);
    end
  end

  // Cleared on every IDLE entry, so an aborted or finished burst never leaks
  // its count into the next line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    beat_cnt <= '0;
    else if (state_d == IDLE)    beat_cnt <= '0;
    else if (beat_take || wr_go) beat_cnt <= beat_cnt + CNT_W'(1);
  end

  // The current beat is merged with the earlier slots here. This lets the
  // completed line be registered into resp_rdata on the same edge that takes
  // the last beat, so the line is valid together with resp.
  always_comb begin
    line_next           = line_q;
    line_next[beat_cnt] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q  <= '0;
      rdata_q <= '0;
    end else if (beat_take) begin
      line_q <= line_next;
      if (last_beat) rdata_q <= line_next;
    end
  end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter
//   Randomized self-checking bench for bmem_line_adapter. The bench drives the
//   arbiter and bmem sides directly. It predicts every output from the
//   transaction it issued: the beat list, the stall pattern, and the last
//   completed read line.
module tb_bmem_line_adapter;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
`ifdef BMEM_RADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [LINE_BITS-1:0] last_line = '0;

  bmem_line_adapter_if #(.LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS)) bus ();

  bmem_line_adapter #(.LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_BITS-1:0] got,
                     input logic [LINE_BITS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] v;
    for (int i = 0; i < LINE_BITS/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Randomizes every input. rv_ok allows stray read beats in the cycle.
  // req_ok allows unaccepted requests in the cycle.
  task automatic junk(input bit rv_ok, input bit req_ok);
    bus.req_read    = req_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.req_write   = req_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.req_addr    = $urandom;
    bus.req_wdata   = rand_line();
    bus.bmem_ready  = 1'($urandom_range(0, 1));
    bus.bmem_rvalid = rv_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.bmem_raddr  = $urandom;
    bus.bmem_rdata  = {$urandom, $urandom};
  endtask

  task automatic do_read(input logic [31:0] a, input logic [LINE_BITS-1:0] beats,
                         input int cmd_stall, input int lat, input int gap_max,
                         input bit inject);
    logic [31:0] la;
    bit          bad;
    la  = {a[31:5], 5'b0};
    bad = inject && CHECK;
    @(negedge clk); junk(1, 0);
    bus.req_addr = a; bus.req_read = 1'b1; bus.req_write = 1'b0;
    #1 chk("rd_req_ready", bus.req_ready, 1);
    for (int i = 0; i <= cmd_stall; i++) begin
      @(negedge clk); junk(1, 1);
      bus.bmem_ready = (i == cmd_stall);
      #1 chk("rd_cmd_read", bus.bmem_read, 1);
      chk("rd_cmd_addr", bus.bmem_addr, la);
      chk("rd_cmd_busy", bus.req_ready, 0);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); junk(0, 1);
      #1 chk("rd_wait_noread", bus.bmem_read, 0);
      chk("rd_wait_noresp", bus.resp, 0);
    end
    for (int k = 0; k < BEATS; k++) begin
      int gap;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); junk(0, 1);
        #1 chk("rd_gap_noresp", bus.resp, 0);
      end
      if (bad && k == 1) begin
        @(negedge clk); junk(0, 1);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = la ^ 32'h0000_2000;
        #1 chk("rd_err_pulse", bus.err_mismatch, 1);
      end
      @(negedge clk); junk(0, 1);
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = beats[k*BEAT_BITS +: BEAT_BITS];
      bus.bmem_raddr  = la | 32'($urandom_range(0, 31));
      #1 chk("rd_err_quiet", bus.err_mismatch, 0);
      chk("rd_beat_noresp", bus.resp, 0);
    end
    @(negedge clk); junk(1, 1);
    #1 chk("rd_resp", bus.resp, 1);
    chk("rd_line", bus.resp_rdata, beats);
    chk("rd_raddr", bus.resp_raddr, la);
    last_line = beats;
    @(negedge clk); junk(1, 0);
    #1 chk("rd_resp_once", bus.resp, 0);
    chk("rd_back_idle", bus.req_ready, 1);
    chk("rd_line_hold", bus.resp_rdata, last_line);
    chk("rd_idle_noerr", bus.err_mismatch, 0);
  endtask

  // stall_at/stall_len hold bmem_ready low on one chosen beat.
  // rand_stall instead drops bmem_ready at random.
  task automatic do_write(input logic [31:0] a, input logic [LINE_BITS-1:0] wd,
                          input bit also_read, input int stall_at,
                          input int stall_len, input bit rand_stall);
    logic [31:0] la;
    int k, cyc, st;
    bit rdy;
    la = {a[31:5], 5'b0};
    k = 0; cyc = 0; st = 0;
    @(negedge clk); junk(1, 0);
    bus.req_addr = a; bus.req_write = 1'b1; bus.req_read = also_read; bus.req_wdata = wd;
    #1 chk("wr_req_ready", bus.req_ready, 1);
    while (k < BEATS && cyc < 64) begin
      @(negedge clk); junk(1, 1);
      if (rand_stall) rdy = ($urandom_range(0, 2) != 0);
      else            rdy = !(k == stall_at && st < stall_len);
      if (!rdy) st++;
      bus.bmem_ready = rdy;
      #1 chk("wr_write", bus.bmem_write, 1);
      chk("wr_data", bus.bmem_wdata, wd[k*BEAT_BITS +: BEAT_BITS]);
      chk("wr_addr", bus.bmem_addr, la);
      chk("wr_noread", bus.bmem_read, 0);
      if (rdy) k++;
      cyc++;
    end
    if (k < BEATS) chk("wr_timeout", 0, 1);
    @(negedge clk); junk(1, 1);
    #1 chk("wr_resp", bus.resp, 1);
    chk("wr_line_kept", bus.resp_rdata, last_line);
    chk("wr_raddr", bus.resp_raddr, la);
    chk("wr_done", bus.bmem_write, 0);
    @(negedge clk); junk(1, 0);
    #1 chk("wr_resp_once", bus.resp, 0);
    chk("wr_back_idle", bus.req_ready, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 1);
    chk({tag, "_bread"}, bus.bmem_read, 0);
    chk({tag, "_bwrite"}, bus.bmem_write, 0);
    chk({tag, "_resp"}, bus.resp, 0);
    chk({tag, "_err"}, bus.err_mismatch, 0);
    chk({tag, "_baddr"}, bus.bmem_addr, 0);
    chk({tag, "_bwdata"}, bus.bmem_wdata, 0);
    chk({tag, "_rdata"}, bus.resp_rdata, 0);
    chk({tag, "_raddr"}, bus.resp_raddr, 0);
  endtask

  // Starts a read and feeds two beats, then pulses reset in the middle of the third.
  task automatic do_abort(input logic [31:0] a);
    @(negedge clk); junk(1, 0);
    bus.req_addr = a; bus.req_read = 1'b1; bus.req_write = 1'b0;
    @(negedge clk); junk(1, 1);
    bus.bmem_ready = 1'b1;
    #1 chk("ab_cmd", bus.bmem_read, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); junk(0, 1);
      bus.bmem_rvalid = 1'b1; bus.bmem_raddr = a;
    end
    @(negedge clk); junk(0, 1);
    bus.bmem_rvalid = 1'b1; bus.bmem_raddr = a;
    #2 rst = 1'b0;
    #1 reset_checks("ab_rst");
    last_line = '0;
    @(negedge clk); junk(1, 0); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); junk(1, 0);
      #1 chk("ab_no_resp", bus.resp, 0);
      chk("ab_idle", bus.req_ready, 1);
    end
  endtask

  initial begin
    logic [LINE_BITS-1:0] abcd;
    bus.req_addr = '0; bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    #1 reset_checks("por");
    @(negedge clk); @(negedge clk); rst = 1'b1;

    do_read(32'h0000_1020, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 0, 0);
    abcd = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
            64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    do_write(32'h0000_2000, abcd, 0, -1, 0, 0);
    do_write(32'h0000_2000, abcd, 0, 2, 3, 0);
    do_write(32'h0000_0040, rand_line(), 1, -1, 0, 0);
    do_abort(32'h0000_5000);
    do_read(32'h0000_5000, rand_line(), 1, 2, 1, 0);
    do_read(32'h0000_1000, rand_line(), 0, 1, 0, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 3), 2,
                1'($urandom_range(0, 1)));
      else
        do_write($urandom, rand_line(), 1'($urandom_range(0, 1)), -1, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
